reg_operand_reader: RTL and testbench
=====================================

Name: reg_operand_reader

Overview:
- Read side of the register file scoreboard.
- Accepts one instruction at a time from decode and fetches its two source operands from the register cells.
- Stalls while a source is write-reserved, taking data from the write-back bus as soon as it appears. Stalls also while the destination is reserved (WAW).
- Once both operands are resolved, emits the destination's write-reserve pulse and presents operands to execute with a valid/ready handshake.

Parameters:
W_OPR, 32, operand/data width
N_REG, 16, number of register cells
W_ADDR, 4, register address width (log2 N_REG)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  decode offers instruction
in_ready  out  1  unit can accept (state IDLE)
in_rs1  in  W_ADDR  source A address
in_rs2  in  W_ADDR  source B address
in_rd  in  W_ADDR  destination address
in_rd_we  in  1  instruction writes rd
rf_raddr_a  out  W_ADDR  read address A (= latched rs1)
rf_raddr_b  out  W_ADDR  read address B (= latched rs2)
rf_rdata_a  in  W_OPR  register cell data A (combinational)
rf_rdata_b  in  W_OPR  register cell data B
rsv_vec  in  N_REG  write-reserve bit of every cell
wb_valid  in  1  write-back this cycle
wb_addr  in  W_ADDR  write-back destination
wb_data  in  W_OPR  write-back data
reserve_o  out  1  one-cycle write-reserve pulse
reserve_addr_o  out  W_ADDR  cell to reserve
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
opa_o  out  W_OPR  resolved operand A
opb_o  out  W_OPR  resolved operand B
rd_o  out  W_ADDR  destination
rd_we_o  out  1  write-enable passthrough
stall_cnt_o  out  16  cycles spent stalled; saturating

Behaviour:
- States: IDLE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch rs1/rs2/rd/rd_we, clear both resolved flags, go to WAIT.
- WAIT, per operand, once per cycle while unresolved, in priority order:
  - addr==0: value 0, resolved; r0 is never reserved.
  - wb_valid && wb_addr==addr: take wb_data, resolved. Bypass beats rf_rdata.
  - !rsv_vec[addr]: take rf_rdata, resolved.
  - Otherwise stay unresolved.
- WAIT, other rules:
  - A resolved operand is frozen; later write-backs do not change it.
  - rs1==rs2 resolve identically in the same cycle.
- WAW check, needed only when rd_we && rd!=0:
  - rd is clear if !rsv_vec[rd], or if wb_valid && wb_addr==rd this cycle.
- Leaving WAIT:
  - Condition: both operands resolved (including same-cycle) and the WAW check is clear.
  - Assert reserve_o=1, reserve_addr_o=rd in that cycle, only if rd_we && rd!=0. Go to OUT.
  - reserve_o is never asserted in any other cycle.
- OUT:
  - out_valid=1; opa_o/opb_o/rd_o/rd_we_o held stable.
  - out_ready=1 -> IDLE next cycle.
  - No new accept in the same cycle; throughput is at most one instruction per 3 cycles.
- Minimum latency:
  - Accept at cycle T, reserve pulse at T+1, out_valid at T+2.
- stall_cnt_o:
  - +1 for each WAIT cycle that does not leave WAIT; saturates at 0xFFFF.
  - Not incremented in OUT backpressure cycles.
- rf_raddr_a/b are driven from latched addresses in all states (0 after reset).
- Reset (rst=1 at clk edge, any state):
  - State IDLE; out_valid=0, reserve_o=0, opa_o/opb_o=0, rd_o=0, rd_we_o=0, stall_cnt_o=0, latched addresses 0.
  - In-flight instruction dropped; no reserve pulse issued.
  - in_ready=0 during the reset cycle, 1 after.
- Simultaneous events:
  - wb_valid to the address being reserved in the exit cycle: the exit still happens. The reserve pulse is for the new write.
  - wb_valid to an already-resolved address: ignored.

Test Plan:
- No hazard: rsv_vec=0, rf r3=0x11, r4=0x22; issue rs1=3, rs2=4, rd=5, we=1 at T -> reserve_o@T+1 addr 5; out_valid@T+2 opa=0x11, opb=0x22; stall_cnt=0.
- RAW stall + bypass: rsv_vec[3]=1; issue rs1=3, rs2=0; wb_valid addr 3 data 0xDEAD 4 cycles later -> opa=0xDEAD, opb=0; stall_cnt=3; reserve pulse in the wb cycle.
- WAW: rsv_vec[5]=1, sources clear, rd=5, we=1 -> no reserve until rsv_vec[5] drops or wb addr 5; single pulse only.
- r0 / no-write: rs1=0, rs2=0, rd=0, we=1 with rsv_vec=all ones -> opa=opb=0; no reserve_o; out_valid@T+2.
- Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0, stall_cnt unchanged; then out_ready=1 -> IDLE, next instruction accepted.
- Reset mid-WAIT: rsv_vec[7]=1, issue rs1=7, assert rst for 1 cycle -> all outputs 0, no reserve_o, state IDLE; next issue works normally.

Source files
------------

// File: rtl/reg_operand_reader.sv
// Read side of the register-file scoreboard: fetches two source operands,
// stalls on reserved sources or a reserved destination, then hands off to execute.
module reg_operand_reader #(
    parameter int W_OPR  = 32,
    parameter int N_REG  = 16,
    parameter int W_ADDR = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_ADDR-1:0] in_rs1,
    input  logic [W_ADDR-1:0] in_rs2,
    input  logic [W_ADDR-1:0] in_rd,
    input  logic              in_rd_we,
    output logic [W_ADDR-1:0] rf_raddr_a,
    output logic [W_ADDR-1:0] rf_raddr_b,
    input  logic [W_OPR-1:0]  rf_rdata_a,
    input  logic [W_OPR-1:0]  rf_rdata_b,
    input  logic [N_REG-1:0]  rsv_vec,
    input  logic              wb_valid,
    input  logic [W_ADDR-1:0] wb_addr,
    input  logic [W_OPR-1:0]  wb_data,
    output logic              reserve_o,
    output logic [W_ADDR-1:0] reserve_addr_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_OPR-1:0]  opa_o,
    output logic [W_OPR-1:0]  opb_o,
    output logic [W_ADDR-1:0] rd_o,
    output logic              rd_we_o,
    output logic [15:0]       stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

    state_t            state, state_nxt;
    logic [W_ADDR-1:0] rs1_q, rs2_q, rd_q;
    logic              rd_we_q, res_a_q, res_b_q;
    logic [W_OPR-1:0]  opa_q, opb_q;
    logic [15:0]       stall_q;

    logic              a_ok, b_ok, waw_clear, leave, reserve_need;
    logic [W_OPR-1:0]  a_val, b_val;

    // Resolution priority: r0, then write-back bypass, then an unreserved cell.
    always_comb begin
        a_ok  = res_a_q;
        a_val = opa_q;
        if (!res_a_q) begin
            if (rs1_q == '0) begin
                a_ok  = 1'b1;
                a_val = '0;
            end else if (wb_valid && wb_addr == rs1_q) begin
                a_ok  = 1'b1;
                a_val = wb_data;
            end else if (!rsv_vec[rs1_q]) begin
                a_ok  = 1'b1;
                a_val = rf_rdata_a;
            end
        end
    end

    always_comb begin
        b_ok  = res_b_q;
        b_val = opb_q;
        if (!res_b_q) begin
            if (rs2_q == '0) begin
                b_ok  = 1'b1;
                b_val = '0;
            end else if (wb_valid && wb_addr == rs2_q) begin
                b_ok  = 1'b1;
                b_val = wb_data;
            end else if (!rsv_vec[rs2_q]) begin
                b_ok  = 1'b1;
                b_val = rf_rdata_b;
            end
        end
    end

    assign reserve_need = rd_we_q && (rd_q != '0);
    assign waw_clear    = !reserve_need || !rsv_vec[rd_q] || (wb_valid && wb_addr == rd_q);
    assign leave        = a_ok && b_ok && waw_clear;

    always_comb begin
        state_nxt = state;
        reserve_o = 1'b0;
        case (state)
            IDLE: if (in_valid) state_nxt = WAIT;
            WAIT: if (leave) begin
                state_nxt = OUT;
                reserve_o = reserve_need;
            end
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) reserve_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            res_a_q <= 1'b0;
            res_b_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            stall_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    rs1_q   <= in_rs1;
                    rs2_q   <= in_rs2;
                    rd_q    <= in_rd;
                    rd_we_q <= in_rd_we;
                    res_a_q <= 1'b0;
                    res_b_q <= 1'b0;
                end
                WAIT: begin
                    res_a_q <= a_ok;
                    res_b_q <= b_ok;
                    opa_q   <= a_val;
                    opb_q   <= b_val;
                    if (!leave && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (state == IDLE) && !rst;
    assign out_valid      = (state == OUT) && !rst;
    assign rf_raddr_a     = rs1_q;
    assign rf_raddr_b     = rs2_q;
    assign reserve_addr_o = rd_q;
    assign opa_o          = opa_q;
    assign opb_o          = opb_q;
    assign rd_o           = rd_q;
    assign rd_we_o        = rd_we_q;
    assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_reg_operand_reader.sv
// Bench for reg_operand_reader: table of instruction scenarios with timed
// write-back / reserve-drop events, scoreboard of expected operands, reset corner case.
module tb_reg_operand_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_we;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic [15:0] rsv_vec;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        reserve_o;
    logic [3:0]  reserve_addr_o;
    logic        out_valid, out_ready;
    logic [31:0] opa_o, opb_o;
    logic [3:0]  rd_o;
    logic        rd_we_o;
    logic [15:0] stall_cnt_o;

    logic [31:0] regs [16];

    always #5 clk = ~clk;

    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];

    reg_operand_reader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rsv_vec(rsv_vec),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .reserve_o(reserve_o), .reserve_addr_o(reserve_addr_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .opa_o(opa_o), .opb_o(opb_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
        .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        logic [3:0]  rs1, rs2, rd;
        logic        we;
        logic [15:0] rsv;
        int          wb_at;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        int          drop_at;
        int          drop_bit;
        int          bp;
        logic [31:0] opa, opb;
        logic        res;
        int          res_k;
        int          out_k;
        int          stall;
    } vec_t;

    typedef struct {
        logic [31:0] opa, opb;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_exp = 0;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rs1, rs2, rd, input logic we,
                                input logic [15:0] rsv, input int wb_at,
                                input logic [3:0] wba, input logic [31:0] wbd,
                                input int drop_at, drop_bit, bp,
                                input logic [31:0] opa, opb, input logic res,
                                input int res_k, out_k, stall);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.rsv = rsv;
        v.wb_at = wb_at; v.wb_addr = wba; v.wb_data = wbd;
        v.drop_at = drop_at; v.drop_bit = drop_bit; v.bp = bp;
        v.opa = opa; v.opb = opb; v.res = res; v.res_k = res_k;
        v.out_k = out_k; v.stall = stall;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e, got;
        int          k, res_cnt, res_k, out_k;
        logic [3:0]  res_addr;
        bit          done;
        string       tag;
        tag = $sformatf("v%0d", idx);
        e.opa = v.opa; e.opb = v.opb; e.rd = v.rd; e.we = v.we;
        sb.push_back(e);
        res_cnt = 0; res_k = 0; out_k = 0; res_addr = '0; done = 0;
        in_valid = 1'b1; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_rd_we = v.we;
        rsv_vec = v.rsv; wb_valid = 1'b0; out_ready = (v.bp == 0);
        #1;
        check({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!done && k <= 40) begin
            wb_valid = (k == v.wb_at);
            wb_addr  = v.wb_addr;
            wb_data  = v.wb_data;
            if (v.drop_at == k) rsv_vec[v.drop_bit] = 1'b0;
            #1;
            if (reserve_o) begin
                res_cnt++;
                res_k = k;
                res_addr = reserve_addr_o;
            end
            if (out_valid) begin
                done = 1;
                out_k = k;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        wb_valid = 1'b0;
        if (!done) begin
            check({tag, " out_valid timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            if (sb.size() == 0) begin
                check({tag, " scoreboard empty"}, 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                check({tag, " opa"}, opa_o, got.opa);
                check({tag, " opb"}, opb_o, got.opb);
                check({tag, " rd"}, {28'd0, rd_o}, {28'd0, got.rd});
                check({tag, " rd_we"}, {31'd0, rd_we_o}, {31'd0, got.we});
            end
            check({tag, " out cycle"}, out_k, v.out_k);
            check({tag, " stall_cnt"}, {16'd0, stall_cnt_o}, stall_exp + v.stall);
            check({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
            for (int i = 1; i <= v.bp; i++) begin
                @(negedge clk);
                #1;
                if (reserve_o) res_cnt++;
                check({tag, " bp out_valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, " bp opa"}, opa_o, v.opa);
                check({tag, " bp opb"}, opb_o, v.opb);
                check({tag, " bp in_ready"}, {31'd0, in_ready}, 32'd0);
                check({tag, " bp stall_cnt"}, {16'd0, stall_cnt_o}, stall_exp + v.stall);
            end
            out_ready = 1'b1;
            @(negedge clk);
            #1;
            check({tag, " back to idle"}, {31'd0, out_valid}, 32'd0);
        end
        check({tag, " reserve count"}, res_cnt, v.res ? 32'd1 : 32'd0);
        if (v.res) begin
            check({tag, " reserve cycle"}, res_k, v.res_k);
            check({tag, " reserve addr"}, {28'd0, res_addr}, {28'd0, v.rd});
        end
        stall_exp += v.stall;
        rsv_vec = '0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 | i;
        regs[3] = 32'h11;
        regs[4] = 32'h22;

        //               rs1 rs2 rd  we rsv       wb_at wba  wbd           drop bit bp opa          opb          res rk ok st
        vecs[0]  = mk(3, 4, 5, 1, 16'h0000, 0, 0, 32'h0,      0, 0, 0, 32'h11,     32'h22,     1, 1, 2, 0);
        vecs[1]  = mk(3, 0, 6, 1, 16'h0008, 4, 3, 32'hDEAD,   0, 0, 0, 32'hDEAD,   32'h0,      1, 4, 5, 3);
        vecs[2]  = mk(3, 4, 5, 1, 16'h0020, 0, 0, 32'h0,      3, 5, 0, 32'h11,     32'h22,     1, 3, 4, 2);
        vecs[3]  = mk(3, 4, 5, 1, 16'h0020, 2, 5, 32'h1234,   0, 0, 0, 32'h11,     32'h22,     1, 2, 3, 1);
        vecs[4]  = mk(0, 0, 0, 1, 16'hFFFF, 0, 0, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 2, 0);
        vecs[5]  = mk(9, 9, 2, 0, 16'h0200, 2, 9, 32'hCAFE,   0, 0, 0, 32'hCAFE,   32'hCAFE,   0, 0, 3, 1);
        vecs[6]  = mk(3, 4, 7, 1, 16'h0000, 1, 4, 32'hBEEF,   0, 0, 0, 32'h11,     32'hBEEF,   1, 1, 2, 0);
        vecs[7]  = mk(3, 4, 8, 1, 16'h0010, 2, 3, 32'h5555,   3, 4, 0, 32'h11,     32'h22,     1, 3, 4, 2);
        vecs[8]  = mk(3, 4, 10, 1, 16'h0000, 0, 0, 32'h0,     0, 0, 5, 32'h11,     32'h22,     1, 1, 2, 0);
        vecs[9]  = mk(3, 4, 5, 1, 16'h0000, 1, 5, 32'h77,     0, 0, 0, 32'h11,     32'h22,     1, 1, 2, 0);
        vecs[10] = mk(3, 4, 5, 0, 16'h0020, 0, 0, 32'h0,      0, 0, 0, 32'h11,     32'h22,     0, 0, 2, 0);
        vecs[11] = mk(3, 4, 11, 1, 16'h0008, 0, 0, 32'h0,     2, 3, 0, 32'h11,     32'h22,     1, 2, 3, 1);

        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        rsv_vec = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset reserve", {31'd0, reserve_o}, 32'd0);
        check("reset stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("reset raddr_a", {28'd0, rf_raddr_a}, 32'd0);
        check("reset opa", opa_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset while stalled on a reserved source: instruction dropped, no pulse.
        rsv_vec = 16'h0080;
        in_valid = 1'b1; in_rs1 = 4'd7; in_rs2 = 4'd0; in_rd = 4'd9; in_rd_we = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rstwait stalled reserve", {31'd0, reserve_o}, 32'd0);
        check("rstwait stalled out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait reserve in rst", {31'd0, reserve_o}, 32'd0);
        check("rstwait in_ready in rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstwait out_valid", {31'd0, out_valid}, 32'd0);
        check("rstwait reserve", {31'd0, reserve_o}, 32'd0);
        check("rstwait opa", opa_o, 32'd0);
        check("rstwait opb", opb_o, 32'd0);
        check("rstwait rd", {28'd0, rd_o}, 32'd0);
        check("rstwait rd_we", {31'd0, rd_we_o}, 32'd0);
        check("rstwait stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("rstwait raddr_a", {28'd0, rf_raddr_a}, 32'd0);
        check("rstwait in_ready", {31'd0, in_ready}, 32'd1);
        stall_exp = 0;
        rsv_vec = '0;
        @(negedge clk);
        run_vec(12, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
